gamma_seg7_ctrl: RTL

- Parametrised successor of the gamma-selection 7-segment display driver.
- Takes a raw switch vector of NUM_SEL gamma selections and synchronises and debounces it.
- Resolves it by priority, highest set bit wins, into a committed gamma index and value in tenths.
- Drives NUM_DIGITS active-low 7-segment digits showing "U.T" on HEX1/HEX0, with an optional blink-on-change indication. Also hands the committed index to the downstream gamma LUT with a one-cycle update strobe.

---
 rtl/gamma_seg7_pkg.sv | 31 +++
 rtl/seg7_hex_enc.sv | 11 +
 rtl/gamma_seg7_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/gamma_seg7_pkg.sv
// Shared types, hex font and gamma lookup for the gamma selection display driver.
package gamma_seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;

  // Active-low hex font, bit0 = segment a
  localparam seg7_t HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    BLINK  = 2'd2,
    SHOW   = 2'd3
  } state_t;

  function automatic logic [4:0] gamma_tenths(input logic [3:0] idx);
    if (idx == 4'd0) begin
      gamma_tenths = 5'd10;
    end else if (idx <= 4'd4) begin
      gamma_tenths = 5'd5 + {1'b0, idx};
    end else begin
      gamma_tenths = 5'd6 + {1'b0, idx};
    end
  endfunction

endpackage

// File: rtl/seg7_hex_enc.sv
// Combinational 4-bit value to active-low 7-segment pattern.
module seg7_hex_enc
  import gamma_seg7_pkg::*;
(
  input  logic [3:0] val,
  output seg7_t      seg
);

  assign seg = HEX_FONT[val];

endmodule

// File: rtl/gamma_seg7_ctrl.sv
// Debounced priority gamma selector with "U.T" 7-segment readout and LUT update strobe.
// Blink-on-change indication is built only when GAMMA_SEG7_BLINK_EN is defined.
module gamma_seg7_ctrl
  import gamma_seg7_pkg::*;
#(
  parameter int NUM_SEL       = 10,
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 50000,
  parameter int BLINK_HALF    = 12500000,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic                         iCLK,
  input  logic                         iRST_N,
  input  logic [NUM_SEL-1:0]           iSW,
  output logic [7*NUM_DIGITS-1:0]      oSEG,
  output logic [$clog2(NUM_SEL+1)-1:0] oGAMMA_IDX,
  output logic [4:0]                   oGAMMA_TENTHS,
  output logic                         oVALID,
  output logic                         oUPD
);

  localparam int IDX_W = $clog2(NUM_SEL + 1);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int SEG_W = 7 * NUM_DIGITS;

  logic [NUM_SEL-1:0] sw_meta, sw_s, sw_prev, committed_vec, cand;
  logic [CNT_W-1:0]   cnt;
  state_t             state, state_next;
  logic               stable_change;
  logic [IDX_W-1:0]   cand_idx;
  logic               cand_valid, cand_changed;
  logic [4:0]         cand_tenths, disp_tenths;
  logic               disp_blank;
  logic [3:0]         units_digit, frac_digit;
  seg7_t              units_seg, frac_seg;
  logic [SEG_W-1:0]   seg_next;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sw_meta <= {NUM_SEL{1'b0}};
      sw_s    <= {NUM_SEL{1'b0}};
      sw_prev <= {NUM_SEL{1'b0}};
      cnt     <= {CNT_W{1'b0}};
    end else begin
      sw_meta <= iSW;
      sw_s    <= sw_meta;
      sw_prev <= sw_s;
      if (sw_s != sw_prev) begin
        cnt <= {CNT_W{1'b0}};
      end else if (cnt != CNT_W'(STABLE_CYCLES)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // sw_s == sw_prev keeps a fresh edge from riding on a count left over from the old vector
  assign stable_change = (sw_s == sw_prev) && (cnt >= CNT_W'(STABLE_CYCLES - 1)) &&
                         (sw_s != committed_vec);

  always_comb begin
    cand_idx = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_SEL; i++) begin
      cand_idx = cand[i] ? IDX_W'(i) : cand_idx;
    end
    cand_valid   = |cand;
    cand_tenths  = cand_valid ? gamma_tenths(4'(cand_idx)) : 5'd0;
    cand_changed = (cand_idx != oGAMMA_IDX) || (cand_valid != oVALID);
  end

`ifdef GAMMA_SEG7_BLINK_EN
  localparam int HALF_W = $clog2(BLINK_HALF + 1);
  localparam int TOG_W  = $clog2(BLINK_TOGGLES + 1);

  logic [HALF_W-1:0] half_cnt;
  logic [TOG_W-1:0]  tog_cnt;
  logic              half_end, blink_done, blink_blank;

  assign half_end    = (half_cnt == HALF_W'(BLINK_HALF - 1));
  assign blink_done  = half_end && (tog_cnt == TOG_W'(BLINK_TOGGLES - 1));
  assign blink_blank = (state == BLINK) && !tog_cnt[0];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      half_cnt <= {HALF_W{1'b0}};
      tog_cnt  <= {TOG_W{1'b0}};
    end else if (state == COMMIT) begin
      half_cnt <= {HALF_W{1'b0}};
      tog_cnt  <= {TOG_W{1'b0}};
    end else if (state == BLINK) begin
      if (half_end) begin
        half_cnt <= {HALF_W{1'b0}};
        tog_cnt  <= tog_cnt + TOG_W'(1);
      end else begin
        half_cnt <= half_cnt + HALF_W'(1);
      end
    end
  end
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, SHOW: begin
        if (stable_change) state_next = COMMIT;
        else               state_next = state;
      end
      COMMIT: begin
`ifdef GAMMA_SEG7_BLINK_EN
        state_next = cand_changed ? BLINK : SHOW;
`else
        state_next = SHOW;
`endif
      end
      BLINK: begin
`ifdef GAMMA_SEG7_BLINK_EN
        if (stable_change)   state_next = COMMIT;
        else if (blink_done) state_next = SHOW;
        else                 state_next = BLINK;
`else
        state_next = SHOW;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // During COMMIT the display is fed the incoming values so oSEG moves on the same edge as oUPD
  always_comb begin
    disp_tenths = (state == COMMIT) ? cand_tenths : oGAMMA_TENTHS;
    disp_blank  = (state == COMMIT) ? !cand_valid : !oVALID;
`ifdef GAMMA_SEG7_BLINK_EN
    disp_blank  = disp_blank || blink_blank;
`endif
    if (disp_tenths >= 5'd20) begin
      units_digit = 4'd2;
      frac_digit  = 4'(disp_tenths - 5'd20);
    end else if (disp_tenths >= 5'd10) begin
      units_digit = 4'd1;
      frac_digit  = 4'(disp_tenths - 5'd10);
    end else begin
      units_digit = 4'd0;
      frac_digit  = 4'(disp_tenths);
    end
  end

  seg7_hex_enc u_enc_frac  (.val(frac_digit),  .seg(frac_seg));
  seg7_hex_enc u_enc_units (.val(units_digit), .seg(units_seg));

  always_comb begin
    seg_next = {SEG_W{1'b1}};
    if (!disp_blank) begin
      seg_next[6:0]  = frac_seg;
      seg_next[13:7] = units_seg;
    end else begin
      seg_next = {SEG_W{1'b1}};
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cand          <= {NUM_SEL{1'b0}};
      committed_vec <= {NUM_SEL{1'b0}};
      oGAMMA_IDX    <= {IDX_W{1'b0}};
      oGAMMA_TENTHS <= 5'd0;
      oVALID        <= 1'b0;
      oUPD          <= 1'b0;
      oSEG          <= {SEG_W{1'b1}};
    end else begin
      if (stable_change && (state != COMMIT)) begin
        cand <= sw_s;
      end
      if (state == COMMIT) begin
        committed_vec <= cand;
        oGAMMA_IDX    <= cand_idx;
        oGAMMA_TENTHS <= cand_tenths;
        oVALID        <= cand_valid;
      end
      oUPD <= (state == COMMIT) && cand_changed;
      oSEG <= seg_next;
    end
  end

endmodule
